// File: rtl/crashlog_arb_pkg.sv
// rtl/crashlog_arb_pkg.sv - shared encodings for the crashlog trigger arbiter
package crashlog_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ASSERT  = 2'b01,
    ST_HOLDOFF = 2'b10
  } state_t;

  localparam int NUM_SRC = 3;

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_CATERR = 2'd1;
  localparam logic [1:0] SRC_GLBRST = 2'd2;
  localparam logic [1:0] SRC_BMC    = 2'd3;

  // Fixed priority: CATERR > GLBRSTWARN > BMC
  function automatic logic [1:0] pick_src(input logic [NUM_SRC-1:0] pend);
    if (pend[0])      return SRC_CATERR;
    else if (pend[1]) return SRC_GLBRST;
    else if (pend[2]) return SRC_BMC;
    else              return SRC_NONE;
  endfunction

endpackage

// File: rtl/sync_fall_det.sv
// rtl/sync_fall_det.sv - 2-flop synchronizer with falling-edge pulse, flops reset to 1
module sync_fall_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_n,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= sig_n;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;

endmodule

// File: rtl/crashlog_trig_arbiter.sv
// rtl/crashlog_trig_arbiter.sv - arbitrates three crashlog sources into one fixed-width PCH trigger
module crashlog_trig_arbiter
  import crashlog_arb_pkg::*;
#(
  parameter int PULSE_CYC   = 200,
  parameter int HOLDOFF_CYC = 2000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iCpuCatErr_n,
  input  logic       iFmGlbRstWarn_n,
  input  logic       iFmBmcCrashLogTrig_n,
  input  logic       iStatusClr,
  output logic       oFmPchCrashlogTrig_n,
  output logic       oBusy,
  output logic [1:0] oGrantSrc,
  output logic [2:0] oStatus,
  output logic       oOverrun
);

  localparam int MAX_CYC = (PULSE_CYC > HOLDOFF_CYC) ? PULSE_CYC : HOLDOFF_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLDOFF_CYC - 1);

  logic [NUM_SRC-1:0] src_n, ev, pend, grant_hot, ovr_set;
  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               start_grant;
  logic [1:0]         grant_pick;
  logic               trig_n_nxt;

  assign src_n = {iFmBmcCrashLogTrig_n, iFmGlbRstWarn_n, iCpuCatErr_n};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
    sync_fall_det u_det (
      .clk  (iClk),
      .rst  (iRst),
      .sig_n(src_n[i]),
      .fall (ev[i])
    );
  end

  assign grant_pick = pick_src(pend);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    start_grant = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pend) begin
          state_nxt   = ST_ASSERT;
          cnt_nxt     = PULSE_LOAD;
          start_grant = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLDOFF;
          cnt_nxt   = HOLD_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    grant_hot = '0;
    if (start_grant) begin
      case (grant_pick)
        SRC_CATERR: grant_hot = 3'b001;
        SRC_GLBRST: grant_hot = 3'b010;
        SRC_BMC:    grant_hot = 3'b100;
        default:    grant_hot = 3'b000;
      endcase
    end
    oBusy      = (state == ST_ASSERT) || (state == ST_HOLDOFF);
    trig_n_nxt = (state_nxt != ST_ASSERT);
  end

  // A source that is being granted this cycle is not "already pending" for a new event
  assign ovr_set = ev & pend & ~grant_hot;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oFmPchCrashlogTrig_n <= 1'b1;
      oGrantSrc            <= SRC_NONE;
      pend                 <= '0;
      oStatus              <= '0;
      oOverrun             <= 1'b0;
    end else begin
      oFmPchCrashlogTrig_n <= trig_n_nxt;
      if (start_grant) oGrantSrc <= grant_pick;
      pend     <= ev | (pend & ~grant_hot);
      oStatus  <= ev | (oStatus & ~{NUM_SRC{iStatusClr}});
      oOverrun <= (|ovr_set) | (oOverrun & ~iStatusClr);
    end
  end

endmodule

// File: tb/tb_crashlog_trig_arbiter.sv
// tb/tb_crashlog_trig_arbiter.sv - scoreboard bench for the crashlog trigger arbiter
module tb_crashlog_trig_arbiter;

  localparam int P = 4;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cat_n = 1'b1, glb_n = 1'b1, bmc_n = 1'b1, clr = 1'b0;
  logic       trig_n, busy, overrun;
  logic [1:0] gsrc;
  logic [2:0] status;

  logic       d_cat_n = 1'b1;
  logic       d_trig_n, d_busy, d_ovr;
  logic [1:0] d_gsrc;
  logic [2:0] d_status;

  always #5 clk = ~clk;

  crashlog_trig_arbiter #(.PULSE_CYC(P), .HOLDOFF_CYC(H)) dut (
    .iClk(clk), .iRst(rst),
    .iCpuCatErr_n(cat_n), .iFmGlbRstWarn_n(glb_n), .iFmBmcCrashLogTrig_n(bmc_n),
    .iStatusClr(clr),
    .oFmPchCrashlogTrig_n(trig_n), .oBusy(busy), .oGrantSrc(gsrc),
    .oStatus(status), .oOverrun(overrun)
  );

  crashlog_trig_arbiter dut_d (
    .iClk(clk), .iRst(rst),
    .iCpuCatErr_n(d_cat_n), .iFmGlbRstWarn_n(1'b1), .iFmBmcCrashLogTrig_n(1'b1),
    .iStatusClr(1'b0),
    .oFmPchCrashlogTrig_n(d_trig_n), .oBusy(d_busy), .oGrantSrc(d_gsrc),
    .oStatus(d_status), .oOverrun(d_ovr)
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: events are input falls seen two edges later; a grant may
  // happen once the previous grant's pulse + hold-off + one idle cycle elapsed.
  typedef struct {int src; int at;} exp_t;
  exp_t     sb_q[$];
  bit       samp[3][16];
  bit [2:0] m_pend, m_status;
  bit       m_ovr, m_gvalid;
  int       m_free, m_last_g, m_gsrc;

  always @(posedge clk or posedge rst) begin
    bit [2:0] in_now, ev, after;
    int s;
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 16; j++) samp[i][j] = 1'b1;
      m_pend = '0; m_status = '0; m_ovr = 1'b0;
      m_free = 0; m_gvalid = 1'b0; m_gsrc = 0; m_last_g = 0;
      sb_q.delete();
    end else begin
      edge_n++;
      in_now = {bmc_n, glb_n, cat_n};
      for (int i = 0; i < 3; i++) samp[i][edge_n & 15] = in_now[i];
      after = m_pend;
      if (edge_n >= m_free && m_pend != 3'b000) begin
        s = m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
        after[s] = 1'b0;
        m_gsrc   = s + 1;
        m_last_g = edge_n;
        m_gvalid = 1'b1;
        m_free   = edge_n + P + H + 1;
        sb_q.push_back('{m_gsrc, edge_n});
      end
      for (int i = 0; i < 3; i++)
        ev[i] = (samp[i][(edge_n - 2) & 15] == 1'b0) && (samp[i][(edge_n - 3) & 15] == 1'b1);
      if (clr) begin
        m_status = '0;
        m_ovr    = 1'b0;
      end
      if ((ev & after) != 3'b000) m_ovr = 1'b1;
      m_status = m_status | ev;
      m_pend   = after | ev;
    end
  end

  bit in_pulse;
  int low_cnt, rise_edge, last_gap, pulse_count;
  int seen_src[$];

  always @(negedge clk) begin
    bit m_busy, m_trig;
    exp_t e;
    if (rst) begin
      in_pulse = 1'b0;
      low_cnt  = 0;
    end else begin
      m_busy = m_gvalid && ((edge_n - m_last_g) < P + H);
      m_trig = !(m_gvalid && ((edge_n - m_last_g) < P));
      chk("trig_n", trig_n, m_trig);
      chk("busy", busy, m_busy);
      chk("grant_src", gsrc, m_gsrc);
      chk("status", status, m_status);
      chk("overrun", overrun, m_ovr);
      if (!trig_n && !in_pulse) begin
        in_pulse = 1'b1;
        low_cnt  = 1;
        pulse_count++;
        seen_src.push_back(gsrc);
        last_gap = edge_n - rise_edge;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: src %0d at edge %0d, none expected", gsrc, edge_n);
        end else begin
          e = sb_q.pop_front();
          chk("pulse_src", gsrc, e.src);
          chk("pulse_start", edge_n, e.at);
        end
      end else if (!trig_n) begin
        low_cnt++;
      end else if (in_pulse) begin
        chk("pulse_width", low_cnt, P);
        in_pulse  = 1'b0;
        rise_edge = edge_n;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_quiet(input int limit);
    int run = 0;
    for (int k = 0; k < limit && run < 8; k++) begin
      step(1);
      if (!busy && trig_n && m_pend == 3'b000 && sb_q.size() == 0) run++;
      else run = 0;
    end
    chk("quiet_reached", int'(run >= 8), 1);
  endtask

  task automatic wait_trig(input logic level, input int limit);
    for (int k = 0; k < limit; k++) begin
      step(1);
      if (trig_n == level) break;
    end
    chk("wait_trig", trig_n, level);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, s0, low_d, busy_d;
    step(3);
    chk("rst_trig_n", trig_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_grant", gsrc, 0);
    chk("rst_status", status, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    step(3);

    // held-low CATERR gives one pulse
    p0 = pulse_count;
    cat_n = 1'b0;
    wait_quiet(100);
    chk("t1_pulses", pulse_count - p0, 1);
    chk("t1_grant", gsrc, 1);
    chk("t1_status", status, 3'b001);
    cat_n = 1'b1;
    step(3);
    pulse_clr();
    chk("clr_status", status, 0);

    // simultaneous GLBRST + BMC
    p0 = pulse_count; s0 = seen_src.size();
    glb_n = 1'b0; bmc_n = 1'b0;
    step(4);
    glb_n = 1'b1; bmc_n = 1'b1;
    wait_quiet(200);
    chk("t2_pulses", pulse_count - p0, 2);
    chk("t2_first", seen_src[s0], 2);
    chk("t2_second", seen_src[s0 + 1], 3);
    chk("t2_gap", last_gap, H + 1);
    chk("t2_status", status, 3'b110);
    pulse_clr();

    // BMC during pulse, CATERR during hold-off: CATERR overtakes
    p0 = pulse_count; s0 = seen_src.size();
    glb_n = 1'b0;
    wait_trig(1'b0, 20);
    step(1);
    bmc_n = 1'b0;
    step(2);
    bmc_n = 1'b1;
    wait_trig(1'b1, 20);
    step(2);
    cat_n = 1'b0;
    step(3);
    cat_n = 1'b1; glb_n = 1'b1;
    wait_quiet(300);
    chk("t3_pulses", pulse_count - p0, 3);
    chk("t3_g0", seen_src[s0], 2);
    chk("t3_g1", seen_src[s0 + 1], 1);
    chk("t3_g2", seen_src[s0 + 2], 3);
    pulse_clr();

    // BMC re-falls while pending: merged, overrun
    p0 = pulse_count; s0 = seen_src.size();
    cat_n = 1'b0;
    step(1);
    for (int k = 0; k < 3; k++) begin
      bmc_n = 1'b0;
      step(2);
      bmc_n = 1'b1;
      step(2);
    end
    cat_n = 1'b1;
    wait_quiet(200);
    chk("t4_pulses", pulse_count - p0, 2);
    chk("t4_g0", seen_src[s0], 1);
    chk("t4_g1", seen_src[s0 + 1], 3);
    chk("t4_overrun", overrun, 1);
    pulse_clr();
    chk("t4_ovr_clr", overrun, 0);
    chk("t4_stat_clr", status, 0);
    bmc_n = 1'b0;
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("t4_set_wins", status, 3'b100);
    wait_quiet(100);
    bmc_n = 1'b1;
    step(3);
    pulse_clr();

    // async reset two cycles into a pulse
    cat_n = 1'b0;
    wait_trig(1'b0, 20);
    step(1);
    #2 rst = 1'b1;
    cat_n = 1'b1;
    #1;
    chk("t5_trig_n", trig_n, 1);
    chk("t5_busy", busy, 0);
    chk("t5_grant", gsrc, 0);
    chk("t5_status", status, 0);
    chk("t5_overrun", overrun, 0);
    step(3);
    rst = 1'b0;
    p0 = pulse_count;
    step(20);
    chk("t5_no_pulse", pulse_count - p0, 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(9) == 0) cat_n = ~cat_n;
      if ($urandom_range(9) == 0) glb_n = ~glb_n;
      if ($urandom_range(9) == 0) bmc_n = ~bmc_n;
      clr = ($urandom_range(63) == 0);
      step(1);
    end
    cat_n = 1'b1; glb_n = 1'b1; bmc_n = 1'b1; clr = 1'b0;
    wait_quiet(500);

    // default parameters
    low_d = 0; busy_d = 0;
    d_cat_n = 1'b0;
    for (int k = 0; k < 2400; k++) begin
      step(1);
      if (!d_trig_n) low_d++;
      if (d_busy) busy_d++;
    end
    chk("t6_low", low_d, 200);
    chk("t6_busy", busy_d, 2200);
    chk("t6_grant", d_gsrc, 1);
    chk("t6_status", d_status, 3'b001);

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
